symbol_sequencer: RTL and testbench
===================================

# symbol_sequencer

Word-to-symbol sequencer for the Zigbee TX path. It registers a 32-bit payload word and steps the 2-bit byte select of the downstream 4:1 byte multiplexer. It takes the selected byte back and splits it into 4-bit symbols for the chip-spreading stage, low nibble first, under valid/ready handshakes on both sides.

## Interface
Parameters:
- LOW_NIBBLE_FIRST, 1, 1: bits [3:0] of each byte go out before [7:4]; 0: reversed order.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset: one clock; synchronous, active-low.
- inWordValid  input  1  upstream word available.
- inWord  input  32  payload word; byte 0 = [7:0].
- outWordReady  output  1  block can accept a word this cycle.
- outWord  output  32  registered word, drives the byte multiplexer data input.
- outSel  output  2  byte index, drives the byte multiplexer select.
- inByte  input  8  selected byte returned by the multiplexer (combinational from outWord/outSel).
- outSymValid  output  1  symbol valid.
- outSym  output  4  current symbol.
- outSymLast  output  1  marks the final symbol (8th) of the word.
- inSymReady  input  1  downstream accepts a symbol.

## Operation
- States: IDLE, NIB0, NIB1. The state is encoded in 2 bits.
- IDLE: outSymValid=0, outWordReady=1. On inWordValid: capture inWord into outWord, set outSel=0, and go to NIB0.
- NIB0: outSymValid=1. outSym is the first nibble of inByte. On inSymReady, go to NIB1.
- NIB1: outSymValid=1. outSym is the second nibble of inByte. On inSymReady:
  - If outSel<3: outSel+1, go to NIB0.
  - If outSel==3 and inWordValid: load the new word, outSel=0, go to NIB0. This is a zero-bubble chain.
  - If outSel==3 and no inWordValid: go to IDLE.
- outWordReady = (state==IDLE) | (state==NIB1 & outSel==3 & inSymReady). It is forced to 0 while rst_n=0.
- outSymLast = (state==NIB1 & outSel==3).
- outSel increments only in NIB1 on acceptance. It never wraps past 3 within a word.
- Valid/ready rule: once outSymValid=1, outSym, outSymLast, outSel and outWord hold stable until inSymReady=1. outSymValid never drops without a handshake, except on reset.
- inWordValid is ignored when outWordReady=0. Upstream must hold the word.
- Reset value of every output: outWord=0, outSel=0, outSymValid=0, outSym=0, outSymLast=0, outWordReady=0 during reset and 1 on the first cycle after release.
- Reset mid-word: the word is discarded and no further symbols are produced. The state returns to IDLE on the next edge with rst_n=0.

## Timing
- Word accepted at edge N: first symbol valid from cycle N+1.
- Each symbol needs at least 1 cycle. A word occupies at least 8 cycles.
- With continuous inSymReady and inWordValid, throughput is 1 symbol/cycle with no gaps between words.
- Latency from inByte to outSym is combinational. The multiplexer path plus the nibble mux must meet one clock period. No register is placed on inByte.
- Backpressure (inSymReady=0) stalls in the current state indefinitely, with all outputs held.

## Structure
- Shared package zigbee_pkg:
  - Constants WORD_W=32, BYTE_W=8, SYM_W=4, BYTES_PER_WORD=4, SYMS_PER_WORD=8.
  - Enum seq_state_t {IDLE, NIB0, NIB1}.
- One sub-module is natural: nibble_select. It is combinational: byte in, phase bit and LOW_NIBBLE_FIRST in, 4-bit symbol out.
- The byte multiplexer stays external; this block only drives its select and data inputs.

## Test plan
- Load 0xA1B2C3D4, inSymReady=1 constantly: outSym sequence 4,D,3,C,2,B,1,A with outSel 0,0,1,1,2,2,3,3. outSymLast is high only on A. outWordReady is 0 during the sequence and returns to 1 after A.
- Two words back-to-back (0x000000FF then 0x12345678) with inWordValid held: F,F,0,0,0,0,0,0 then 8,7,6,5,4,3,2,1 with no idle cycle. outWordReady pulses on the last symbol of word 1.
- Backpressure: inSymReady toggled 1,0,0,1 on word 0x0000005A: symbol A is held stable for 3 cycles and is not duplicated. The full sequence is still A,5,0,0,0,0,0,0.
- Reset asserted on the 3rd symbol of 0xDEADBEEF: the next cycle has outSymValid=0, outSel=0, outWord=0. After release, outWordReady=1 and no stale symbols appear.
- LOW_NIBBLE_FIRST=0 with 0xA1B2C3D4: sequence D,4,C,3,B,2,A,1.
- inWordValid asserted while mid-word (outSel=1): the word is not captured. outWord is unchanged until the final handshake.

Source files
------------

// File: rtl/zigbee_pkg.sv
// Shared Zigbee TX-path constants and the symbol sequencer state type.
package zigbee_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int SYM_W          = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int SYMS_PER_WORD  = 8;

  localparam logic [1:0] LAST_SEL = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NIB0 = 2'd1,
    NIB1 = 2'd2
  } seq_state_t;

endpackage

// File: rtl/symbol_sequencer_nibble_select.sv
// Picks one 4-bit symbol out of a byte; phase 0 is the first symbol sent.
module nibble_select
  import zigbee_pkg::*;
#(
  parameter bit LOW_NIBBLE_FIRST = 1'b1
) (
  input  logic [BYTE_W-1:0] byte_val,
  input  logic              phase,
  output logic [SYM_W-1:0]  sym
);

  logic take_high;

  always_comb begin
    take_high = LOW_NIBBLE_FIRST ? phase : ~phase;
    sym       = take_high ? byte_val[7:4] : byte_val[3:0];
  end

endmodule

// File: rtl/symbol_sequencer.sv
// Word-to-symbol sequencer: holds a payload word, steps the external byte mux
// select and emits two nibble symbols per returned byte under valid/ready.
module symbol_sequencer
  import zigbee_pkg::*;
#(
  parameter bit LOW_NIBBLE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inWordValid,
  input  logic [WORD_W-1:0] inWord,
  output logic              outWordReady,
  output logic [WORD_W-1:0] outWord,
  output logic [1:0]        outSel,
  input  logic [BYTE_W-1:0] inByte,
  output logic              outSymValid,
  output logic [SYM_W-1:0]  outSym,
  output logic              outSymLast,
  input  logic              inSymReady
);

  seq_state_t       state;
  seq_state_t       state_next;
  logic             at_last_sel;
  logic             word_take;
  logic [SYM_W-1:0] sym_raw;

  assign at_last_sel = (outSel == LAST_SEL);
  assign word_take   = outWordReady & inWordValid;

  nibble_select #(
    .LOW_NIBBLE_FIRST(LOW_NIBBLE_FIRST)
  ) u_nibble_select (
    .byte_val(inByte),
    .phase   (state == NIB1),
    .sym     (sym_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (inWordValid) state_next = NIB0;
      NIB0: if (inSymReady) state_next = NIB1;
      NIB1: begin
        if (inSymReady) begin
          if (!at_last_sel || inWordValid) begin
            state_next = NIB0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready on the last symbol handshake lets the next word chain in with no bubble.
  always_comb begin
    outSymValid  = (state == NIB0) || (state == NIB1);
    outSymLast   = (state == NIB1) && at_last_sel;
    outWordReady = rst_n && ((state == IDLE) ||
                             ((state == NIB1) && at_last_sel && inSymReady));
    outSym       = outSymValid ? sym_raw : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outWord <= '0;
      outSel  <= '0;
    end else if (word_take) begin
      outWord <= inWord;
      outSel  <= '0;
    end else if ((state == NIB1) && inSymReady && !at_last_sel) begin
      outSel <= outSel + 2'd1;
    end
  end

endmodule

// File: tb/tb_symbol_sequencer.sv
// Directed self-checking bench for symbol_sequencer; a second instance runs
// the reversed nibble order in lockstep off the same inputs.
module tb_symbol_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_word_valid;
  logic [31:0] in_word;
  logic        in_sym_ready;

  logic        out_word_ready, rev_word_ready;
  logic [31:0] out_word, rev_word;
  logic [1:0]  out_sel, rev_sel;
  logic [7:0]  in_byte, rev_byte;
  logic        out_sym_valid, rev_sym_valid;
  logic [3:0]  out_sym, rev_sym;
  logic        out_sym_last, rev_sym_last;

  int compare_count  = 0;
  int mismatch_count = 0;

  always #5 clk = ~clk;

  // External 4:1 byte multiplexers
  assign in_byte  = out_word[{out_sel, 3'b000} +: 8];
  assign rev_byte = rev_word[{rev_sel, 3'b000} +: 8];

  symbol_sequencer #(.LOW_NIBBLE_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .inWordValid(in_word_valid), .inWord(in_word),
    .outWordReady(out_word_ready), .outWord(out_word), .outSel(out_sel),
    .inByte(in_byte),
    .outSymValid(out_sym_valid), .outSym(out_sym), .outSymLast(out_sym_last),
    .inSymReady(in_sym_ready)
  );

  symbol_sequencer #(.LOW_NIBBLE_FIRST(1'b0)) u_dut_rev (
    .clk(clk), .rst_n(rst_n),
    .inWordValid(in_word_valid), .inWord(in_word),
    .outWordReady(rev_word_ready), .outWord(rev_word), .outSel(rev_sel),
    .inByte(rev_byte),
    .outSymValid(rev_sym_valid), .outSym(rev_sym), .outSymLast(rev_sym_last),
    .inSymReady(in_sym_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Present a word while idle and check it is accepted on that edge.
  task automatic applyStimulus(input string tag, input logic [31:0] word);
    in_word       = word;
    in_word_valid = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_load_rdy"}, 32'(out_word_ready), 32'd1);
    @(posedge clk); #1;
    in_word_valid = 1'b0;
  endtask

  // Eight symbols with inSymReady held high; seq holds expected symbols low-first.
  task automatic expectWord(input string tag, input logic [31:0] exp_word,
                            input logic [31:0] seq, input logic [31:0] seq_rev,
                            input bit check_rev, input int raise_at,
                            input logic [31:0] next_word);
    for (int i = 0; i < 8; i++) begin
      if (i == raise_at) begin
        in_word_valid = 1'b1;
        in_word       = next_word;
      end
      @(negedge clk);
      checkOutput($sformatf("%s_valid%0d", tag, i), 32'(out_sym_valid), 32'd1);
      checkOutput($sformatf("%s_sym%0d", tag, i), 32'(out_sym), 32'(seq[4*i +: 4]));
      checkOutput($sformatf("%s_sel%0d", tag, i), 32'(out_sel), 32'(i / 2));
      checkOutput($sformatf("%s_last%0d", tag, i), 32'(out_sym_last), 32'(i == 7));
      checkOutput($sformatf("%s_rdy%0d", tag, i), 32'(out_word_ready), 32'(i == 7));
      checkOutput($sformatf("%s_word%0d", tag, i), out_word, exp_word);
      if (check_rev) begin
        checkOutput($sformatf("%s_revsym%0d", tag, i), 32'(rev_sym),
                    32'(seq_rev[4*i +: 4]));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_sym_valid), 32'd0);
    checkOutput({tag, "_rdy"}, 32'(out_word_ready), 32'd1);
    checkOutput({tag, "_last"}, 32'(out_sym_last), 32'd0);
    checkOutput({tag, "_sym"}, 32'(out_sym), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    in_word_valid = 1'b0;
    in_word       = '0;
    in_sym_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset values");
    @(negedge clk);
    checkOutput("rst_rdy", 32'(out_word_ready), 32'd0);
    checkOutput("rst_valid", 32'(out_sym_valid), 32'd0);
    checkOutput("rst_word", out_word, 32'd0);
    checkOutput("rst_sel", 32'(out_sel), 32'd0);
    checkOutput("rst_sym", 32'(out_sym), 32'd0);
    checkOutput("rst_last", 32'(out_sym_last), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkIdle("rst_release");

    $display("[TB] single word, both nibble orders");
    in_sym_ready = 1'b1;
    applyStimulus("t1", 32'hA1B2C3D4);
    expectWord("t1", 32'hA1B2C3D4, 32'hA1B2C3D4, 32'h1A2B3C4D, 1'b1, 8, 32'd0);
    checkIdle("t1_idle");

    $display("[TB] back-to-back words");
    applyStimulus("t2", 32'h000000FF);
    expectWord("t2a", 32'h000000FF, 32'h000000FF, 32'd0, 1'b0, 0, 32'h12345678);
    in_word_valid = 1'b0;
    expectWord("t2b", 32'h12345678, 32'h12345678, 32'd0, 1'b0, 8, 32'd0);
    checkIdle("t2_idle");

    $display("[TB] backpressure");
    in_sym_ready = 1'b0;
    applyStimulus("t3", 32'h0000005A);
    for (int k = 0; k < 3; k++) begin
      in_sym_ready = (k == 2);
      @(negedge clk);
      checkOutput($sformatf("t3_hold_sym%0d", k), 32'(out_sym), 32'hA);
      checkOutput($sformatf("t3_hold_valid%0d", k), 32'(out_sym_valid), 32'd1);
      checkOutput($sformatf("t3_hold_sel%0d", k), 32'(out_sel), 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_sym%0d", i), 32'(out_sym), (i == 1) ? 32'h5 : 32'h0);
      checkOutput($sformatf("t3_sel%0d", i), 32'(out_sel), 32'(i / 2));
      checkOutput($sformatf("t3_last%0d", i), 32'(out_sym_last), 32'(i == 7));
      @(posedge clk); #1;
    end
    checkIdle("t3_idle");

    $display("[TB] reset mid-word");
    applyStimulus("t4", 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t4_sym0", 32'(out_sym), 32'hF);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t4_sym1", 32'(out_sym), 32'hE);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t4_sym2", 32'(out_sym), 32'hE);
    checkOutput("t4_rst_rdy", 32'(out_word_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t4_post_valid", 32'(out_sym_valid), 32'd0);
    checkOutput("t4_post_sel", 32'(out_sel), 32'd0);
    checkOutput("t4_post_word", out_word, 32'd0);
    checkOutput("t4_post_rdy", 32'(out_word_ready), 32'd1);
    @(posedge clk); #1;
    checkIdle("t4_idle_a");
    checkIdle("t4_idle_b");

    $display("[TB] word offered mid-word");
    applyStimulus("t6", 32'h11223344);
    expectWord("t6a", 32'h11223344, 32'h11223344, 32'd0, 1'b0, 2, 32'hCAFEF00D);
    in_word_valid = 1'b0;
    expectWord("t6b", 32'hCAFEF00D, 32'hCAFEF00D, 32'd0, 1'b0, 8, 32'd0);
    checkIdle("t6_idle");

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***",
             compare_count, mismatch_count);
    $finish;
  end

endmodule
